fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin write-port arbiter feeding asyn_fifo's write side. Shares the single
//  wr_en/wdata port among NUM_REQ valid/ready requesters in the wr_clk domain.
//  Grants bursts of up to BURST_LEN beats, never writes while full, and keeps beat/error stats.
// PARAMETERS
//  NUM_REQ     4   number of requesters (>=2)
//  DATA_WIDTH  8   FIFO data width; must match asyn_fifo wdata
//  BURST_LEN   4   max beats accepted per grant (>=1)
//  CNT_WIDTH   16  width of beats_total counter
// PORTS
//  wr_clk       in   1                   clock: the FIFO write clock; single clock domain
//  rst          in   1                   reset, asynchronous, active-low
//  req_valid    in   NUM_REQ             per-requester data valid
//  req_data     in   NUM_REQ*DATA_WIDTH  requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready    out  NUM_REQ             per-requester accept; beat transfers on valid&ready
//  full         in   1                   asyn_fifo full (write domain)
//  overflow     in   1                   asyn_fifo overflow flag
//  wr_en        out  1                   FIFO write enable
//  wdata        out  DATA_WIDTH          FIFO write data
//  owner        out  $clog2(NUM_REQ)     current grant holder (valid when busy)
//  busy         out  1                   1 in BURST state
//  beats_total  out  CNT_WIDTH           count of beats written; wraps at 2^CNT_WIDTH
//  err_overflow out  1                   sticky: overflow seen while rst high
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, owner=0, rr_ptr=0 (req 0 highest priority first),
//    beat_cnt=0, beats_total=0, err_overflow=0; req_ready=0, wr_en=0, wdata=0 via decode.
//  - FSM states IDLE, BURST (registered).
//    IDLE: req_ready=0, wr_en=0. If any req_valid, pick first valid index scanning
//      rr_ptr, rr_ptr+1, ... mod NUM_REQ; next cycle state=BURST, owner=winner, beat_cnt=0.
//      Else stay IDLE. One bubble cycle per grant is by design.
//    BURST: req_ready[owner]=~full, all others 0. wr_en=req_valid[owner]&~full
//      (combinational); wdata=req_data[owner] when wr_en, else 0.
//      On beat (wr_en): beat_cnt++, beats_total++.
//      Release to IDLE when: beat accepted and beat_cnt==BURST_LEN-1, or
//      req_valid[owner]==0 (including before first beat). On release rr_ptr=owner+1 mod NUM_REQ.
//      full==1 with valid held: stay BURST, no beat, beat_cnt unchanged (no timeout).
//  - wr_en is never 1 while full==1, in any state.
//  - Requester must hold valid/data stable until ready (AXI-style); dropping valid ends the burst.
//  - NUM_REQ not a power of 2: pointer increments wrap explicitly at NUM_REQ-1 -> 0.
//  - err_overflow sets on any cycle overflow==1; clears only on reset.
//  - Reset asserted mid-burst: burst abandoned immediately, no partial state kept.
// STRUCTURE
//  - fifo_arb_pkg: typedef enum logic {IDLE,BURST} arb_state_t; localparam IDX_W=$clog2(NUM_REQ)
//    helper; shared with the bench scoreboard for state decode.
//  - Sub-module rr_pick: combinational round-robin picker (req vector, ptr) -> (any, idx).
//  - Top holds FSM, beat_cnt, rr_ptr, stats, output muxing.
// TESTING
//  1 Reset: rst=0 mid-traffic -> all outputs 0, state IDLE within same cycle; release -> req0 first.
//  2 Single requester: req_valid=4'b0010, 10 beats 0x01..0x0A, full=0 -> bursts of 4,4,2 (owner=1),
//    1-cycle gap between bursts, beats_total=10, FIFO readback 0x01..0x0A in order.
//  3 Fairness: all 4 valid continuously, BURST_LEN=4 -> owner sequence 0,1,2,3,0 with 4 beats each.
//  4 Backpressure: full=1 for 5 cycles mid-burst -> wr_en=0, req_ready=0, beat_cnt held, resume after.
//  5 Early drop: owner 2 drops valid after 1 beat -> release, rr_ptr=3, next grant req3 if valid.
//  6 Overflow: force overflow=1 for 1 cycle -> err_overflow=1 and stays 1 until rst=0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter and its bench.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   localparam int unsigned NUM_REQ_DEF = 4;

   // Index width for n items; never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned IDX_W = idx_w(NUM_REQ_DEF);

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester handshake plus FIFO write-side signals shared by the arbiter.
interface fifo_wr_arbiter_if #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8
);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          full;
   logic                          overflow;
   logic                          wr_en;
   logic [DATA_WIDTH-1:0]         wdata;

   // Arbiter side.
   modport master (
      input  req_valid, req_data, full, overflow,
      output req_ready, wr_en, wdata
   );

   // Requesters and FIFO side.
   modport slave (
      output req_valid, req_data, full, overflow,
      input  req_ready, wr_en, wdata
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning from ptr upwards, wrapping.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               any,
   output logic [IDX_W-1:0]   idx
);

   logic [IDX_W-1:0] cand;

   // Walk candidates ptr, ptr+1, ... with an explicit wrap so non-power-of-2 counts work.
   always_comb begin
      any  = 1'b0;
      idx  = '0;
      cand = ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!any && req[cand]) begin
            any = 1'b1;
            idx = cand;
         end
         cand = (cand == IDX_W'(NUM_REQ - 1)) ? '0 : cand + IDX_W'(1);
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the FIFO write port among NUM_REQ requesters.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned BURST_LEN  = 4,
   parameter int unsigned CNT_WIDTH  = 16,
   localparam int unsigned IdxW      = idx_w(NUM_REQ)
) (
   input  logic                 wr_clk,
   input  logic                 rst,
   fifo_wr_arbiter_if.master    bus,
   output logic [IdxW-1:0]      owner,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] beats_total,
   output logic                 err_overflow
);

   localparam int unsigned BcW = idx_w(BURST_LEN);

   arb_state_t            state_q, state_d;
   logic [IdxW-1:0]       owner_q, owner_d;
   logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [BcW-1:0]        beat_cnt_q, beat_cnt_d;
   logic [CNT_WIDTH-1:0]  beats_total_q;
   logic                  err_overflow_q;

   logic                  pick_any;
   logic [IdxW-1:0]       pick_idx;
   logic                  owner_valid;
   logic [DATA_WIDTH-1:0] owner_data;
   logic                  beat;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IdxW)
   ) u_pick (
      .req (bus.req_valid),
      .ptr (rr_ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   // Select the current owner's valid and data lane.
   always_comb begin
      owner_valid = 1'b0;
      owner_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q == IdxW'(i)) begin
            owner_valid = bus.req_valid[i];
            owner_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Next-state logic and handshake decode; nothing is granted in IDLE.
   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      rr_ptr_d      = rr_ptr_q;
      beat_cnt_d    = beat_cnt_q;
      beat          = 1'b0;
      bus.req_ready = '0;
      bus.wr_en     = 1'b0;
      bus.wdata     = '0;
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d    = BURST;
               owner_d    = pick_idx;
               beat_cnt_d = '0;
            end
         end
         BURST: begin
            for (int i = 0; i < NUM_REQ; i++) begin
               if (owner_q == IdxW'(i)) begin
                  bus.req_ready[i] = ~bus.full;
               end
            end
            beat      = owner_valid & ~bus.full;
            bus.wr_en = beat;
            bus.wdata = beat ? owner_data : '0;
            if (beat) begin
               beat_cnt_d = beat_cnt_q + BcW'(1);
            end
            // Dropping valid ends the burst, even before its first beat.
            if ((beat && (beat_cnt_q == BcW'(BURST_LEN - 1))) || !owner_valid) begin
               state_d    = IDLE;
               beat_cnt_d = '0;
               rr_ptr_d   = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + IdxW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM, grant and round-robin pointer registers.
   always_ff @(posedge wr_clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   // Beat counter (wrapping) and sticky overflow flag.
   always_ff @(posedge wr_clk or negedge rst) begin
      if (!rst) begin
         beats_total_q  <= '0;
         err_overflow_q <= 1'b0;
      end else begin
         if (beat) begin
            beats_total_q <= beats_total_q + CNT_WIDTH'(1);
         end
         if (bus.overflow) begin
            err_overflow_q <= 1'b1;
         end
      end
   end

   assign owner        = owner_q;
   assign busy         = (state_q == BURST);
   assign beats_total  = beats_total_q;
   assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-cycle vector table, scoreboard streams,
// and hand sequences for reset and overflow.
module tb_fifo_wr_arbiter;
   import fifo_arb_pkg::*;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int BL = 4;
   localparam int CW = 16;

   logic          wr_clk = 1'b0;
   logic          rst    = 1'b0;
   logic [1:0]    owner;
   logic          busy;
   logic [CW-1:0] beats_total;
   logic          err_overflow;

   always #5 wr_clk = ~wr_clk;

   fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

   fifo_wr_arbiter #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .BURST_LEN  (BL),
      .CNT_WIDTH  (CW)
   ) dut (
      .wr_clk       (wr_clk),
      .rst          (rst),
      .bus          (bus),
      .owner        (owner),
      .busy         (busy),
      .beats_total  (beats_total),
      .err_overflow (err_overflow)
   );

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [3:0] valid;
      logic       full;
      logic       exp_busy;
      logic [1:0] exp_owner;
      logic [3:0] exp_ready;
      logic       exp_wr;
      logic [7:0] exp_wdata;
   } vec_t;

   typedef struct packed {
      logic [1:0] owner;
      logic [7:0] data;
   } exp_t;

   vec_t          vecs [27];
   logic [DW-1:0] src_q [NR][$];
   exp_t          exp_q [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge wr_clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [3:0] v, input logic f, input logic b,
                               input logic [1:0] o, input logic [3:0] r, input logic w,
                               input logic [7:0] d);
      vec_t t;
      t.valid     = v;
      t.full      = f;
      t.exp_busy  = b;
      t.exp_owner = o;
      t.exp_ready = r;
      t.exp_wr    = w;
      t.exp_wdata = d;
      return t;
   endfunction

   task automatic do_reset();
      rst           = 1'b0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.full      = 1'b0;
      bus.overflow  = 1'b0;
      step();
      step();
      rst = 1'b1;
      for (int i = 0; i < NR; i++) src_q[i].delete();
      exp_q.delete();
   endtask

   // Drive requesters from src_q; every FIFO write must match the head of exp_q.
   task automatic run_stream(input int budget);
      int            k;
      logic [NR-1:0] v;
      logic [NR*DW-1:0] d;
      exp_t          e;
      k = 0;
      for (int c = 0; c < budget; c++) begin
         v = '0;
         d = '0;
         for (int i = 0; i < NR; i++) begin
            if (src_q[i].size() > 0) begin
               v[i]           = 1'b1;
               d[i*DW +: DW]  = src_q[i][0];
            end
         end
         bus.req_valid = v;
         bus.req_data  = d;
         bus.full      = 1'b0;
         if (v == '0 && exp_q.size() == 0) break;
         #2;
         if (bus.wr_en) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL stream_extra_beat: got wdata 0x%0h expected no write", bus.wdata);
            end else begin
               e = exp_q.pop_front();
               check("stream_data", bus.wdata, e.data);
               check("stream_owner", owner, e.owner);
               check("stream_beat_cycle", c, 1 + k + k / BL);
               k++;
            end
         end
         for (int i = 0; i < NR; i++) begin
            if (v[i] && bus.req_ready[i]) void'(src_q[i].pop_front());
         end
         step();
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL stream_timeout: got %0d beats pending expected 0", exp_q.size());
      end
   endtask

   // The FIFO must never be written while it reports full.
   always @(negedge wr_clk) begin
      if (rst && bus.full) check("wr_en_while_full", bus.wr_en, 1'b0);
   end

   initial begin
      arb_state_t exp_st;

      // valid full | busy owner ready wr wdata ; lane i carries 0x11*(i+1)
      vecs[0]  = mk(4'b0000, 0, 0, 0, 4'b0000, 0, 8'h00);
      vecs[1]  = mk(4'b0100, 0, 0, 0, 4'b0000, 0, 8'h00);
      vecs[2]  = mk(4'b0100, 0, 1, 2, 4'b0100, 1, 8'h33);
      vecs[3]  = mk(4'b0100, 1, 1, 2, 4'b0000, 0, 8'h00);
      vecs[4]  = mk(4'b0100, 1, 1, 2, 4'b0000, 0, 8'h00);
      vecs[5]  = mk(4'b0100, 1, 1, 2, 4'b0000, 0, 8'h00);
      vecs[6]  = mk(4'b0100, 0, 1, 2, 4'b0100, 1, 8'h33);
      vecs[7]  = mk(4'b1100, 0, 1, 2, 4'b0100, 1, 8'h33);
      vecs[8]  = mk(4'b1100, 0, 1, 2, 4'b0100, 1, 8'h33);
      vecs[9]  = mk(4'b1100, 0, 0, 0, 4'b0000, 0, 8'h00);
      vecs[10] = mk(4'b1100, 0, 1, 3, 4'b1000, 1, 8'h44);
      vecs[11] = mk(4'b0100, 0, 1, 3, 4'b1000, 0, 8'h00);
      vecs[12] = mk(4'b0100, 0, 0, 0, 4'b0000, 0, 8'h00);
      vecs[13] = mk(4'b0000, 0, 1, 2, 4'b0100, 0, 8'h00);
      vecs[14] = mk(4'b0011, 0, 0, 0, 4'b0000, 0, 8'h00);
      vecs[15] = mk(4'b0011, 0, 1, 0, 4'b0001, 1, 8'h11);
      vecs[16] = mk(4'b0011, 1, 1, 0, 4'b0000, 0, 8'h00);
      vecs[17] = mk(4'b0000, 1, 1, 0, 4'b0000, 0, 8'h00);
      vecs[18] = mk(4'b0011, 1, 0, 0, 4'b0000, 0, 8'h00);
      vecs[19] = mk(4'b0011, 1, 1, 1, 4'b0000, 0, 8'h00);
      vecs[20] = mk(4'b0011, 0, 1, 1, 4'b0010, 1, 8'h22);
      vecs[21] = mk(4'b0000, 0, 1, 1, 4'b0010, 0, 8'h00);
      vecs[22] = mk(4'b0100, 0, 0, 0, 4'b0000, 0, 8'h00);
      vecs[23] = mk(4'b1100, 0, 1, 2, 4'b0100, 1, 8'h33);
      vecs[24] = mk(4'b1000, 0, 1, 2, 4'b0100, 0, 8'h00);
      vecs[25] = mk(4'b1001, 0, 0, 0, 4'b0000, 0, 8'h00);
      vecs[26] = mk(4'b1001, 0, 1, 3, 4'b1000, 1, 8'h44);

      // Reset state.
      rst           = 1'b0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.full      = 1'b0;
      bus.overflow  = 1'b0;
      step();
      step();
      check("rst_busy", busy, 1'b0);
      check("rst_owner", owner, 2'd0);
      check("rst_ready", bus.req_ready, 4'b0000);
      check("rst_wr_en", bus.wr_en, 1'b0);
      check("rst_wdata", bus.wdata, 8'h00);
      check("rst_beats_total", beats_total, 16'd0);
      check("rst_err_overflow", err_overflow, 1'b0);
      rst = 1'b1;

      // Per-cycle vector table: bubble, backpressure, early drops, rotation.
      bus.req_data = 32'h44332211;
      for (int i = 0; i < 27; i++) begin
         bus.req_valid = vecs[i].valid;
         bus.full      = vecs[i].full;
         #2;
         exp_st = arb_state_t'(vecs[i].exp_busy);
         check($sformatf("vec%0d_%s", i, exp_st.name()),
               {busy, (busy ? owner : 2'd0), bus.req_ready, bus.wr_en, bus.wdata},
               {vecs[i].exp_busy, vecs[i].exp_owner, vecs[i].exp_ready,
                vecs[i].exp_wr, vecs[i].exp_wdata});
         step();
      end
      check("table_beats_total", beats_total, 16'd9);

      // Reset mid-burst (owner 3 active): everything clears at once, req0 wins afterwards.
      rst = 1'b0;
      #1;
      check("midrst_outputs", {busy, owner, bus.req_ready, bus.wr_en, bus.wdata},
            {1'b0, 2'd0, 4'b0000, 1'b0, 8'h00});
      check("midrst_beats_total", beats_total, 16'd0);
      step();
      rst = 1'b1;
      #2;
      check("postrst_idle", busy, 1'b0);
      step();
      #2;
      check("postrst_grant", {busy, owner, bus.wr_en, bus.wdata}, {1'b1, 2'd0, 1'b1, 8'h11});
      step();

      // Single requester, 10 beats: bursts of 4,4,2 with a bubble between.
      do_reset();
      for (int j = 1; j <= 10; j++) begin
         src_q[1].push_back(8'(j));
         exp_q.push_back('{owner: 2'd1, data: 8'(j)});
      end
      run_stream(100);
      step();
      check("single_beats_total", beats_total, 16'd10);

      // All four requesters busy: strict 0,1,2,3,0,... rotation with full bursts.
      do_reset();
      for (int i = 0; i < NR; i++) begin
         for (int j = 0; j < 8; j++) src_q[i].push_back(8'(i * 16 + j));
      end
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < NR; i++) begin
            for (int j = 4 * r; j < 4 * r + 4; j++) begin
               exp_q.push_back('{owner: 2'(i), data: 8'(i * 16 + j)});
            end
         end
      end
      run_stream(200);
      step();
      check("fair_beats_total", beats_total, 16'd32);

      // Sticky overflow flag.
      do_reset();
      check("ovf_initial", err_overflow, 1'b0);
      bus.overflow = 1'b1;
      step();
      bus.overflow = 1'b0;
      #2;
      check("ovf_set", err_overflow, 1'b1);
      step();
      step();
      step();
      check("ovf_sticky", err_overflow, 1'b1);
      rst = 1'b0;
      #1;
      check("ovf_cleared", err_overflow, 1'b0);
      step();
      rst = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
